wb_mem_arbiter: RTL and testbench

- Two-master, one-slave Wishbone (pipelined mode) arbiter.
- Shares the single backing-memory port between the instruction-cache master (M0) and the data-cache master (M1, e.g. the write-back data cache).
- Round-robin on simultaneous requests; a grant is held for the whole bus cycle (cyc high) of the owner.
- Sits between the cache controllers and the main memory model.

---
 rtl/wb_mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: two-master, one-slave pipelined Wishbone arbiter.
// M0 is the instruction cache and M1 is the data cache. They share one
// backing-memory port.
// Simultaneous requests are resolved round-robin. An owner keeps the bus
// until it drops cyc. There is always at least one idle cycle between owners.
// Optional feature macro: WB_ARB_TIMEOUT_EN. When it is defined, an owner
// that sees no ack for TIMEOUT_CYCLES owned cycles gets a one-cycle err
// and loses the bus.
module wb_mem_arbiter #(
  parameter int AW             = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          cpu_clock_i,
  input  logic          cpu_reset_i,
  // M0: instruction cache
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  input  logic          m0_we_i,
  input  logic [AW-1:0] m0_adr_i,
  input  logic [31:0]   m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  output logic          m0_stall_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  output logic [31:0]   m0_dat_o,
  // M1: data cache
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  input  logic          m1_we_i,
  input  logic [AW-1:0] m1_adr_i,
  input  logic [31:0]   m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  output logic          m1_stall_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  output logic [31:0]   m1_dat_o,
  // shared memory port
  output logic          s_cyc_o,
  output logic          s_stb_o,
  output logic          s_we_o,
  output logic [AW-1:0] s_adr_o,
  output logic [31:0]   s_dat_o,
  output logic [3:0]    s_sel_o,
  input  logic          s_stall_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  input  logic [31:0]   s_dat_i,
  output logic [1:0]    grant_o
);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_M0   = 2'd1,
    ARB_M1   = 2'd2
  } arb_state_t;

  arb_state_t r_state;
  arb_state_t w_state_nxt;
  logic       r_last_owner;      // 0 = M0 owned last, 1 = M1 owned last
  logic       w_last_owner_nxt;
  logic [1:0] r_grant;
  logic       w_owner_cyc;       // cyc of the current owner, 0 when idle
  logic       w_tmo_hit;         // owner has waited too long for an ack

  assign w_owner_cyc = ((r_state == ARB_M0) && m0_cyc_i) ||
                       ((r_state == ARB_M1) && m1_cyc_i);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;

  // The count holds the number of owned cycles since entry or since the last
  // ack. The first owned cycle reads 1, so the hit lands on owned cycle N.
  assign w_tmo_hit = w_owner_cyc && (r_tmo_cnt == TW'(TIMEOUT_CYCLES));

  // Timeout counter: preset while idle or on ack, otherwise count owned cycles.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      r_tmo_cnt <= TW'(1);
    end else if (r_state == ARB_IDLE) begin
      r_tmo_cnt <= TW'(1);
    end else if (s_ack_i) begin
      r_tmo_cnt <= TW'(1);
    end else begin
      r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
  end
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo = 32'(TIMEOUT_CYCLES);
  assign w_tmo_hit    = 1'b0;
`endif

  // State, round-robin history and registered one-hot grant.
  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      r_state      <= ARB_IDLE;
      r_last_owner <= 1'b0;
      r_grant      <= 2'b00;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_grant      <= {(w_state_nxt == ARB_M1), (w_state_nxt == ARB_M0)};
    end
  end

  // Next-state: grant from idle only; an owner keeps the bus until cyc falls or it times out.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_owner_nxt = r_last_owner;
    case (r_state)
      ARB_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (r_last_owner) begin
            w_state_nxt = ARB_M0;
          end else begin
            w_state_nxt = ARB_M1;
          end
        end else if (m0_cyc_i) begin
          w_state_nxt = ARB_M0;
        end else if (m1_cyc_i) begin
          w_state_nxt = ARB_M1;
        end else begin
          w_state_nxt = ARB_IDLE;
        end
      end
      ARB_M0: begin
        if (!m0_cyc_i || w_tmo_hit) begin
          w_state_nxt      = ARB_IDLE;
          w_last_owner_nxt = 1'b0;
        end else begin
          w_state_nxt = ARB_M0;
        end
      end
      ARB_M1: begin
        if (!m1_cyc_i || w_tmo_hit) begin
          w_state_nxt      = ARB_IDLE;
          w_last_owner_nxt = 1'b1;
        end else begin
          w_state_nxt = ARB_M1;
        end
      end
      default: begin
        w_state_nxt      = ARB_IDLE;
        w_last_owner_nxt = 1'b0;
      end
    endcase
  end

  // Bus routing: the owner is wired through to the slave; non-owners are held off by stall.
  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = '0;
    s_dat_o    = 32'd0;
    s_sel_o    = 4'd0;
    m0_stall_o = m0_cyc_i;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m1_stall_o = m1_cyc_i;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    case (r_state)
      ARB_M0: begin
        s_cyc_o    = m0_cyc_i;
        // A stb that arrives together with a cyc drop is not a transfer.
        s_stb_o    = m0_stb_i & m0_cyc_i;
        s_we_o     = m0_we_i;
        s_adr_o    = m0_adr_i;
        s_dat_o    = m0_dat_i;
        s_sel_o    = m0_sel_i;
        m0_stall_o = s_stall_i;
        // Responses that arrive after the owner has let go are dropped.
        m0_ack_o   = s_ack_i & m0_cyc_i & ~w_tmo_hit;
        m0_err_o   = (s_err_i & m0_cyc_i) | w_tmo_hit;
      end
      ARB_M1: begin
        s_cyc_o    = m1_cyc_i;
        s_stb_o    = m1_stb_i & m1_cyc_i;
        s_we_o     = m1_we_i;
        s_adr_o    = m1_adr_i;
        s_dat_o    = m1_dat_i;
        s_sel_o    = m1_sel_i;
        m1_stall_o = s_stall_i;
        m1_ack_o   = s_ack_i & m1_cyc_i & ~w_tmo_hit;
        m1_err_o   = (s_err_i & m1_cyc_i) | w_tmo_hit;
      end
      default: begin
      end
    endcase
  end

  // Read data goes to both masters; only ack marks it valid.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign grant_o  = r_grant;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed scenarios followed by a
// randomized run checked against an owner/round-robin reference model.
// Build with WB_ARB_TIMEOUT_EN defined to exercise the timeout scenario.
module tb_wb_mem_arbiter;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TMO    = 8;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TMO    = 255;
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [11:0] m0_adr, m1_adr, s_adr;
  logic [31:0] m0_wd, m1_wd, m0_rd, m1_rd, s_wd, s_rd;
  logic [3:0]  m0_sel, m1_sel, s_sel;
  logic        m0_stall, m0_ack, m0_err, m1_stall, m1_ack, m1_err;
  logic        s_cyc, s_stb, s_we, s_stall, s_ack, s_err;
  logic [1:0]  grant;

  int n_vec = 0;
  int n_mis = 0;

  wb_mem_arbiter #(.AW(12), .TIMEOUT_CYCLES(TMO)) dut (
    .cpu_clock_i(clk), .cpu_reset_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_wd), .m0_sel_i(m0_sel), .m0_stall_o(m0_stall), .m0_ack_o(m0_ack),
    .m0_err_o(m0_err), .m0_dat_o(m0_rd),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_wd), .m1_sel_i(m1_sel), .m1_stall_o(m1_stall), .m1_ack_o(m1_ack),
    .m1_err_o(m1_err), .m1_dat_o(m1_rd),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_dat_o(s_wd), .s_sel_o(s_sel), .s_stall_i(s_stall), .s_ack_i(s_ack),
    .s_err_i(s_err), .s_dat_i(s_rd), .grant_o(grant)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state: owner 0=none, 1=M0, 2=M1; last = id of previous owner.
  int md_owner, md_last, md_cnt;
  int own, oc;
  bit hit;
  logic [18:0] e_sbus;
  logic [31:0] e_sdat;
  logic [2:0]  e_m0, e_m1;

  int b, acks, nacc, stall_left, m0_free, early, owned, errc, errs, nstarts, sw;
  bit pend, done, d0, d1;
  logic [1:0]  prev_g;
  logic [1:0]  starts [4];
  logic [1:0]  exp_alt [4];
  logic [11:0] seen [4];

  initial begin
    exp_alt[0] = 2'b10; exp_alt[1] = 2'b01; exp_alt[2] = 2'b10; exp_alt[3] = 2'b01;
    rst = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = 12'h000; m0_wd = 32'd0; m0_sel = 4'hF;
    m1_cyc = 1'b1; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = 12'h000; m1_wd = 32'd0; m1_sel = 4'hF;
    s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_rd = 32'd0;

    // ---- Reset with both masters requesting
    @(negedge clk); #1;
    chk("rst_s_cyc", 64'(s_cyc), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_m0_stall", 64'(m0_stall), 64'd1);
    chk("rst_acks", 64'({m0_ack, m1_ack, m0_err, m1_err}), 64'd0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_first_grant_m1", 64'(grant), 64'd2);
    chk("rst_first_s_cyc", 64'(s_cyc), 64'd1);
    m0_cyc = 1'b0; m1_cyc = 1'b0;
    repeat (2) @(negedge clk);

    // ---- M0 single read of 0x010, acked two cycles after stb
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 12'h010; #1;
    chk("rd_idle_s_cyc", 64'(s_cyc), 64'd0);
    chk("rd_idle_m0_stall", 64'(m0_stall), 64'd1);
    @(negedge clk); #1;
    chk("rd_grant", 64'(grant), 64'd1);
    chk("rd_bus", 64'({s_cyc, s_stb, s_we, s_adr}), 64'({3'b110, 12'h010}));
    chk("rd_m0_stall", 64'(m0_stall), 64'd0);
    m0_stb = 1'b0;
    @(negedge clk);
    @(negedge clk); s_ack = 1'b1; s_rd = 32'hDEADBEEF; #1;
    chk("rd_m0_ack", 64'(m0_ack), 64'd1);
    chk("rd_m0_dat", 64'(m0_rd), 64'hDEADBEEF);
    chk("rd_m1_ack", 64'(m1_ack), 64'd0);
    @(negedge clk); s_ack = 1'b0; m0_cyc = 1'b0; #1;
    chk("rd_ack_once", 64'(m0_ack), 64'd0);
    @(negedge clk); #1;
    chk("rd_grant_idle", 64'(grant), 64'd0);
    chk("rd_s_cyc_idle", 64'(s_cyc), 64'd0);

    // ---- Both request continuously, one beat per bus cycle
    s_ack = 1'b1; d0 = 1'b0; d1 = 1'b0; prev_g = 2'b00; nstarts = 0; sw = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      m0_cyc = !d0; m0_stb = !d0; m1_cyc = !d1; m1_stb = !d1; #1;
      if (grant != 2'b00 && prev_g == 2'b00 && nstarts < 4) begin
        starts[nstarts] = grant;
        nstarts++;
      end
      if (grant != 2'b00 && prev_g != 2'b00 && grant != prev_g) sw++;
      d0 = m0_ack; d1 = m1_ack; prev_g = grant;
    end
    chk("alt_count", 64'(nstarts), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("alt_grant%0d", i), 64'(starts[i]), 64'(exp_alt[i]));
    chk("alt_no_idle_gap", 64'(sw), 64'd0);
    @(negedge clk); m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    repeat (2) @(negedge clk);

    // ---- M1 4-beat evict with a 3-cycle stall on beat 2, M0 waiting
    b = 0; acks = 0; nacc = 0; pend = 1'b0; stall_left = 3; m0_free = 0; early = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      m1_cyc = (acks < 4); m1_stb = (b < 4) && (acks < 4); m1_we = 1'b1;
      m1_adr = 12'h020 + 12'(b); m1_wd = $urandom;
      m0_cyc = (c >= 1); m0_stb = (c >= 1); m0_adr = 12'h100;
      s_ack = pend; s_stall = (b == 1) && (stall_left > 0); #1;
      if (grant != 2'b01 && m0_cyc && !m0_stall) m0_free++;
      if (grant == 2'b01 && m1_cyc) early++;
      pend = 1'b0;
      if (grant == 2'b10 && s_stb && !s_stall) begin
        if (nacc < 4) seen[nacc] = s_adr;
        nacc++; b++; pend = 1'b1;
      end
      if (s_stall) stall_left--;
      if (m1_ack) acks++;
      if (grant == 2'b01) done = 1'b1;
    end
    chk("evict_m0_granted", 64'(done), 64'd1);
    chk("evict_beats", 64'(nacc), 64'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("evict_adr%0d", i), 64'(seen[i]), 64'(12'h020 + 12'(i)));
    chk("evict_m0_stall", 64'(m0_free), 64'd0);
    chk("evict_m0_early", 64'(early), 64'd0);
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_we = 1'b0; s_ack = 1'b0; s_stall = 1'b0;
    repeat (2) @(negedge clk);

    // ---- Ack watchdog (timeout build) or indefinite hold (default build)
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 12'h040; owned = 0; errc = -1; errs = 0;
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 0; c < 30 && errc < 0; c++) begin
      @(negedge clk); #1;
      if (grant == 2'b01) owned++;
      if (m0_err) errc = owned;
    end
    chk("tmo_err_cycle", 64'(errc), 64'(TMO));
    @(negedge clk); s_ack = 1'b1; #1;
    chk("tmo_s_cyc_dropped", 64'(s_cyc), 64'd0);
    chk("tmo_late_ack", 64'(m0_ack), 64'd0);
    chk("tmo_err_once", 64'(m0_err), 64'd0);
`else
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (grant == 2'b01) owned++;
      if (m0_err) errs++;
    end
    chk("hold_owned", 64'(owned), 64'd20);
    chk("hold_no_err", 64'(errs), 64'd0);
`endif
    m0_cyc = 1'b0; m0_stb = 1'b0; s_ack = 1'b0;
    repeat (2) @(negedge clk);

    // ---- Reset in the middle of an M0 burst
    m0_cyc = 1'b1; m0_stb = 1'b1; b = 0; pend = 1'b0;
    for (int c = 0; c < 10 && b < 2; c++) begin
      @(negedge clk);
      m0_adr = 12'h080 + 12'(b); s_ack = pend; #1;
      pend = 1'b0;
      if (grant == 2'b01 && s_stb && !s_stall) begin b++; pend = 1'b1; end
    end
    chk("mid_beats_before_rst", 64'(b), 64'd2);
    @(negedge clk); rst = 1'b1; s_ack = 1'b1; m0_adr = 12'h082; m1_cyc = 1'b1;
    @(negedge clk); #1;
    chk("mid_rst_s_cyc", 64'(s_cyc), 64'd0);
    chk("mid_rst_grant", 64'(grant), 64'd0);
    chk("mid_rst_ack_dropped", 64'(m0_ack), 64'd0);
    rst = 1'b0; s_ack = 1'b0;
    @(negedge clk); #1;
    chk("mid_rst_m1_wins", 64'(grant), 64'd2);
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0;

    // ---- Randomized traffic against the reference model
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    md_owner = 0; md_last = 1; md_cnt = 1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) m0_cyc = ~m0_cyc;
      if ($urandom_range(0, 3) == 0) m1_cyc = ~m1_cyc;
      m0_stb = 1'($urandom); m0_we = 1'($urandom); m0_adr = 12'($urandom);
      m0_wd = $urandom; m0_sel = 4'($urandom);
      m1_stb = 1'($urandom); m1_we = 1'($urandom); m1_adr = 12'($urandom);
      m1_wd = $urandom; m1_sel = 4'($urandom);
      s_stall = ($urandom_range(0, 3) == 0); s_ack = 1'($urandom);
      s_err = ($urandom_range(0, 15) == 0); s_rd = $urandom;
      #1;
      own = md_owner;
      oc  = (own == 1) ? int'(m0_cyc) : (own == 2) ? int'(m1_cyc) : 0;
      hit = TMO_EN && (oc != 0) && (md_cnt == TMO);
      e_sbus = 19'd0; e_sdat = 32'd0;
      e_m0 = {m0_cyc, 2'b00}; e_m1 = {m1_cyc, 2'b00};
      if (own == 1) begin
        e_sbus = {m0_cyc, m0_stb & m0_cyc, m0_we, m0_sel, m0_adr}; e_sdat = m0_wd;
        e_m0 = {s_stall, s_ack && oc != 0 && !hit, (s_err && oc != 0) || hit};
      end
      if (own == 2) begin
        e_sbus = {m1_cyc, m1_stb & m1_cyc, m1_we, m1_sel, m1_adr}; e_sdat = m1_wd;
        e_m1 = {s_stall, s_ack && oc != 0 && !hit, (s_err && oc != 0) || hit};
      end
      chk("rnd_grant", 64'(grant), 64'((own == 1) ? 2'b01 : (own == 2) ? 2'b10 : 2'b00));
      chk("rnd_s_bus", 64'({s_cyc, s_stb, s_we, s_sel, s_adr}), 64'(e_sbus));
      chk("rnd_s_dat", 64'(s_wd), 64'(e_sdat));
      chk("rnd_m0_resp", 64'({m0_stall, m0_ack, m0_err}), 64'(e_m0));
      chk("rnd_m1_resp", 64'({m1_stall, m1_ack, m1_err}), 64'(e_m1));
      chk("rnd_m_dat", {m0_rd, m1_rd}, {s_rd, s_rd});
      // Advance the model: idle grants the requester, preferring whoever did not go last.
      if (own == 0) begin
        if (m0_cyc && m1_cyc) md_owner = 3 - md_last;
        else if (m0_cyc)      md_owner = 1;
        else if (m1_cyc)      md_owner = 2;
        md_cnt = 1;
      end else if (oc == 0 || hit) begin
        md_last  = own;
        md_owner = 0;
      end else begin
        md_cnt = s_ack ? 1 : md_cnt + 1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
